// File: rtl/sia_pkg.sv
// rtl/sia_pkg.sv - shared SIA constants, register map and host FSM encoding
package sia_pkg;

  localparam int DATA_W = 16;

  // Register word addresses, matching adr[2:1] on the bus
  localparam logic [1:0] ADR_CTRL = 2'b00;
  localparam logic [1:0] ADR_STAT = 2'b01;
  localparam logic [1:0] ADR_DATA = 2'b10;
  localparam logic [1:0] ADR_IRQ  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_TOUT
  } state_e;

endpackage

// File: rtl/sia_host_timer.sv
// rtl/sia_host_timer.sv - saturating transfer timer, expired when count equals TIMEOUT
module sia_host_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT));

  // Holds at TIMEOUT so a long stall can never wrap back to a small count
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sia_host.sv
// rtl/sia_host.sv - single-beat Wishbone B4 pipelined master for the SIA register port
module sia_host
  import sia_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:1]        req_adr_i,
  input  logic [1:0]        req_sel_i,
  input  logic [DATA_W-1:0] req_dat_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [1:0]        sel_o,
  output logic [2:1]        adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic              ack_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] dat_i
);

  state_e state_q, state_d;
  logic   accept;
  logic   timer_clr, timer_en, expired;
  logic   cap_ack, cap_tout;

  sia_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  // Outputs decode straight from the state flops, so reset drops cyc/stb at once
  assign req_ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_TOUT);
  assign cyc_o       = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign stb_o       = (state_q == ST_REQ);
  assign rsp_valid_o = (state_q == ST_DONE) || (state_q == ST_TOUT);
  assign rsp_err_o   = (state_q == ST_TOUT);
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    cap_ack   = 1'b0;
    cap_tout  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (req_valid_i) begin
          state_d   = ST_REQ;
          timer_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        timer_en = 1'b1;
        // ACK under STALL is a slave protocol violation and is dropped
        if (!stall_i && ack_i) begin
          state_d = ST_DONE;
          cap_ack = 1'b1;
        end else if (expired) begin
          state_d  = ST_TOUT;
          cap_tout = 1'b1;
        end else if (!stall_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (ack_i) begin
          state_d = ST_DONE;
          cap_ack = 1'b1;
        end else if (expired) begin
          state_d  = ST_TOUT;
          cap_tout = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      we_o  <= 1'b0;
      adr_o <= '0;
      sel_o <= '0;
      dat_o <= '0;
    end else if (accept) begin
      we_o  <= req_we_i;
      adr_o <= req_adr_i;
      sel_o <= req_sel_i;
      dat_o <= req_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rsp_dat_o <= '0;
    end else if (cap_ack) begin
      rsp_dat_o <= dat_i;
    end else if (cap_tout) begin
      rsp_dat_o <= '0;
    end
  end

endmodule

// File: doc/sia_host.md
# sia_host

Wishbone B4 pipelined master that drives the 16-bit SIA register interface on behalf of a simple request/response client (debug port, boot ROM sequencer). It converts one client request into exactly one single-beat Wishbone cycle, honours STALL, waits for ACK, and returns read data or a timeout error. It sits between the client logic and the `sia` slave port, on the same clock.

## Interface

- `TIMEOUT`, default 255: cycles allowed from STB assertion to ACK before the transfer is aborted. Legal range is 1 to 2^16-1.
- `clk_i` in, 1: the single clock.
- `reset_i` in, 1: reset, asynchronous and active-low.
- `req_valid_i` in, 1: a client request is present.
- `req_ready_o` out, 1: the block accepts a request this cycle.
- `req_we_i` in, 1: 1 means write, 0 means read.
- `req_adr_i` in, [2:1]: register word address.
- `req_sel_i` in, [1:0]: byte lanes.
- `req_dat_i` in, 16: write data.
- `rsp_valid_o` out, 1: one-cycle response pulse.
- `rsp_dat_o` out, 16: read data, held until the next response.
- `rsp_err_o` out, 1: the response was a timeout. Valid with `rsp_valid_o`.
- `cyc_o`, `stb_o`, `we_o` out, 1 each: Wishbone controls.
- `sel_o` out, [1:0]; `adr_o` out, [2:1]; `dat_o` out, 16: Wishbone request fields.
- `ack_i`, `stall_i` in, 1 each; `dat_i` in, 16: Wishbone slave responses.

## Operation

- FSM states:
  - IDLE:
    - `req_ready_o=1`.
    - On `req_valid_i` it latches we/adr/sel/dat into the output registers, clears the timer, and goes to REQ.
  - REQ:
    - `cyc_o=stb_o=1`.
    - `stall_i=1`: stay in REQ.
    - `stall_i=0`: the request is accepted and the FSM goes to WAIT.
    - `ack_i` while `stall_i=0` in REQ counts as accept plus acknowledge, and goes to DONE.
  - WAIT:
    - `cyc_o=1`, `stb_o=0`.
    - `ack_i` captures `dat_i` into `rsp_dat_o`. Writes also capture it; the client ignores the value. The FSM then goes to DONE.
  - DONE:
    - `rsp_valid_o=1`, `rsp_err_o=0`, `cyc_o=0`, `req_ready_o=1`.
    - A request arriving in DONE is accepted exactly as in IDLE and goes to REQ. Otherwise the FSM goes to IDLE.
  - TOUT:
    - `rsp_valid_o=1`, `rsp_err_o=1`, `rsp_dat_o=0`, `cyc_o=0`, `req_ready_o=1`.
    - Next state follows the same rules as DONE.
- Timer:
  - Clears on acceptance and increments each cycle in REQ and WAIT.
  - When it reaches `TIMEOUT` without ACK, the FSM goes to TOUT.
  - ACK in the same cycle the timer reaches `TIMEOUT` wins, and the FSM goes to DONE.
  - Width is ceil(log2(TIMEOUT+1)). The timer never wraps.
- `ack_i` outside REQ and WAIT is ignored.
- `ack_i` in REQ with `stall_i=1` is ignored, because it is a protocol violation.
- `we_o`/`adr_o`/`sel_o`/`dat_o` are held stable from REQ entry until the next acceptance.
- Reset asserted at any time, including mid-cycle:
  - State goes to IDLE and `cyc_o`/`stb_o` drop immediately (asynchronously).
  - No response is produced for the aborted transfer.

## Timing

- Every output resets to 0, except `req_ready_o`, which is 1 after reset because the FSM is in IDLE.
- Reference case, SIA with no stall and ACK one cycle after acceptance:
  - cycle 0: request accepted.
  - cycle 1: STB and CYC high.
  - cycle 2: ACK.
  - cycle 3: `rsp_valid_o` and `req_ready_o` both high.
- Minimum request-to-response latency is 3 cycles.
- Back-to-back throughput is one transfer per 3 cycles, because acceptance in DONE overlaps the response.
- Each stall cycle adds one cycle. Each ACK delay cycle adds one cycle.
- Worst case is `TIMEOUT`+2 cycles from acceptance to the TOUT response.
- All outputs are registered. There are no combinational paths from Wishbone inputs to outputs.

## Structure

- Shared package `sia_pkg`:
  - SIA register word-address constants: 2-bit, matching `adr[2:1]`.
  - FSM state encoding: IDLE, REQ, WAIT, DONE, TOUT.
  - Data width constant: 16.
- Natural sub-module: `sia_host_timer`.
  - Saturating up-counter with clear and enable.
  - Output `expired` is asserted when the count equals `TIMEOUT`.
- Everything else is flat in `sia_host`.

## Test plan

- Write with zero-stall responder:
  - Stimulus: `req_we_i=1`, adr=2'b01, sel=2'b11, dat=16'hA55A; responder ACKs one cycle after acceptance.
  - Required: `stb_o` high for exactly 1 cycle; `dat_o`=16'hA55A; `rsp_valid_o` at cycle 3; `rsp_err_o`=0.
- Read with stall:
  - Stimulus: read adr=2'b10; `stall_i` high for 3 cycles, then ACK with `dat_i`=16'h1234.
  - Required: `stb_o` high for 4 cycles; `rsp_dat_o`=16'h1234; `rsp_valid_o` at cycle 6.
- Timeout:
  - Stimulus: `TIMEOUT`=4; the slave never ACKs.
  - Required: `cyc_o` drops after 4 cycles; `rsp_valid_o`=1 with `rsp_err_o`=1 and `rsp_dat_o`=0; `req_ready_o`=1 that cycle.
- Back-to-back:
  - Stimulus: `req_valid_i` held high for three reads; responder returns 16'h0001, 16'h0002, 16'h0003.
  - Required: responses 3 cycles apart with data in order; `cyc_o` low for exactly 1 cycle between transfers.
- Reset during WAIT:
  - Stimulus: drive `reset_i` low in the WAIT state.
  - Required: `cyc_o`=0 immediately; no `rsp_valid_o`. After release, a new read completes normally.
- Stray ACK:
  - Stimulus: pulse `ack_i` in IDLE.
  - Required: no `rsp_valid_o`; state unchanged.
